serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Serial line transmitter: takes a parallel byte over a valid/ready handshake and drives it onto a single-bit serial line.
- Frame format is start bit (0), DATA_W data bits LSB first, an optional even-parity bit, and a stop bit (1).
- It is the driving end of the 1-bit `in`/`out` serial interface used by the lab modules. It feeds receiver-side modules and benches in place of hand-written stimulus.

Parameters:
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on `out`; legal range is 1 or more.
- DATA_W, 8, payload bits per frame.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- data_in  input  DATA_W  byte to send; sampled only on the accepting edge.
- valid  input  1  producer has data_in ready.
- ready  output  1  transmitter can accept a byte this cycle.
- out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset: on a clk edge with rst_n=0 the state goes to IDLE, and the next outputs are out=1, ready=1, busy=0, tx_done=0. The shift register, bit counter and cycle counter all clear.
- Reset mid-frame: abort immediately; out=1 from the next cycle. No tx_done pulse.
- Handshake: transfer happens on an edge where valid=1 and ready=1. ready=1 only in IDLE. data_in is latched into the shift register on that edge; later changes to data_in are ignored.
- Latency: out=0 (start bit) in the first cycle after the accepting edge.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Bit timing: each state holds its bit for exactly CLKS_PER_BIT cycles, counted by a cycle counter that runs 0..CLKS_PER_BIT-1.
- DATA state: DATA_W bits, data_in[0] first. The shift register shifts right at the end of each bit period.
- Parity: the PARITY bit is the XOR of all DATA_W latched bits (even parity).
- STOP: out=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle of STOP, then the state goes to IDLE.
- Frame length: (DATA_W+3)*CLKS_PER_BIT cycles with parity, (DATA_W+2)*CLKS_PER_BIT without.
- busy=1 from START through STOP inclusive. ready = !busy.
- Back-to-back: with valid held high, the next byte is accepted in the single IDLE cycle after STOP. The line therefore stays high for CLKS_PER_BIT+1 cycles between frames.
- CLKS_PER_BIT=1 is legal: one cycle per bit, with no off-by-one at the counter terminal value.
- valid=1 while busy: no effect, no transfer.
- valid with X/Z: not defined; the bench keeps it driven.

Test Plan:
- Reset with rst_n=0 for 3 cycles while valid=1, data_in=8'hFF -> out=1, ready=1, busy=0, no transfer.
- Send 8'hA5 (CLKS_PER_BIT=4, PARITY_EN=1) -> out carries 0,1,0,1,0,0,1,0,1,0,1, each for 4 cycles (44 cycles total). Parity bit is 0. tx_done pulses on cycle 44. ready returns on cycle 45.
- Send 8'h01 (odd number of ones) -> parity bit=1. Frame is 0,1,0,0,0,0,0,0,0,1,1.
- Back-to-back 8'h3C then 8'hC3 with valid held high -> second start bit falls exactly 5 high cycles after the first stop bit begins. Both frames are bit-exact, and 2 tx_done pulses are seen.
- Change data_in to 8'h00 one cycle after accepting 8'hFF -> all 8 data bits on the line are still 1.
- Assert rst_n=0 in the middle of the data bits of a frame -> out=1 from the next cycle, ready=1, no tx_done. A new byte sent after reset is transmitted correctly.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial line transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Accepts one word per valid/ready handshake while idle; the line idles high.
module serial_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              tx_done
);

  // Guard the widths so a single-cycle bit period or a 1-bit payload still gets a 1-bit counter.
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              bit_end;

  assign bit_end = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (valid) begin
          state_d = StStart;
          shreg_d = data_in;
          par_d   = ^data_in;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BitMax) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    out     = 1'b1;
    busy    = 1'b1;
    tx_done = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StStart:  out  = 1'b0;
      StData:   out  = shreg_q[0];
      StParity: out  = par_q;
      StStop:   tx_done = bit_end;
      default:  busy = 1'b0;
    endcase
    ready = !busy;
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx at CLKS_PER_BIT=4, DATA_W=8, PARITY_EN=1.
// Frames are hand-entered as {stop, parity, data, start}, so bit 0 goes on the line first.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       out;
  logic       busy;
  logic       tx_done;

  int vectors = 0;
  int miscompares = 0;

  serial_frame_tx #(
    .CLKS_PER_BIT(4),
    .DATA_W      (8),
    .PARITY_EN   (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .out    (out),
    .busy   (busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Status vector compared everywhere is {out, busy, ready, tx_done}.
  task automatic test_reset();
    rst_n   = 1'b0;
    valid   = 1'b1;
    data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({out, busy, ready, tx_done} !== 4'b1010) begin
        miscompares++;
        $display("FAIL reset_cycle%0d: got %b want 1010", i, {out, busy, ready, tx_done});
      end
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out, busy, ready, tx_done} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 1010", {out, busy, ready, tx_done});
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] b, input logic [10:0] frame);
    int waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready: got %b want 1", name, ready);
    end
    data_in = b;
    valid   = 1'b1;
    @(negedge clk);
    // Accepted on the previous edge; scrambling data_in now must not reach the line.
    valid   = 1'b0;
    data_in = ~b;
    for (int c = 1; c <= 44; c++) begin
      vectors++;
      if ({out, busy, ready, tx_done} !== {frame[(c-1)/4], 1'b1, 1'b0, c == 44}) begin
        miscompares++;
        $display("FAIL %s_cycle%0d: got %b want %b", name, c, {out, busy, ready, tx_done},
                 {frame[(c-1)/4], 1'b1, 1'b0, c == 44});
      end
      @(negedge clk);
    end
    vectors++;
    if ({out, busy, ready, tx_done} !== 4'b1010) begin
      miscompares++;
      $display("FAIL %s_idle: got %b want 1010", name, {out, busy, ready, tx_done});
    end
  endtask

  task automatic test_data_hold();
    test_frame("hold_ff", 8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0});
  endtask

  task automatic test_back_to_back();
    logic [10:0] fa = {1'b1, 1'b0, 8'h3C, 1'b0};
    logic [10:0] fb = {1'b1, 1'b0, 8'hC3, 1'b0};
    logic [3:0]  exp;
    int          pulses = 0;
    @(negedge clk);
    data_in = 8'h3C;
    valid   = 1'b1;
    @(negedge clk);
    data_in = 8'hC3;
    for (int c = 1; c <= 90; c++) begin
      if (c <= 44)      exp = {fa[(c-1)/4], 1'b1, 1'b0, c == 44};
      else if (c == 45) exp = 4'b1010;
      else if (c <= 89) exp = {fb[(c-46)/4], 1'b1, 1'b0, c == 89};
      else              exp = 4'b1010;
      vectors++;
      if ({out, busy, ready, tx_done} !== exp) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got %b want %b", c, {out, busy, ready, tx_done}, exp);
      end
      if (tx_done === 1'b1) pulses++;
      if (c == 46) valid = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 2) begin
      miscompares++;
      $display("FAIL b2b_tx_done_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    data_in = 8'hA5;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (11) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out, busy, ready, tx_done} !== 4'b1010) begin
      miscompares++;
      $display("FAIL midrst_after: got %b want 1010", {out, busy, ready, tx_done});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      vectors++;
      if ({out, tx_done} !== 2'b10) begin
        miscompares++;
        $display("FAIL midrst_quiet%0d: got %b want 10", c, {out, tx_done});
      end
    end
    test_frame("post_rst_5e", 8'h5E, {1'b1, 1'b1, 8'h5E, 1'b0});
  endtask

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b0;
    data_in = 8'h00;
    test_reset();
    test_frame("a5", 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0});
    test_frame("01", 8'h01, {1'b1, 1'b1, 8'h01, 1'b0});
    test_back_to_back();
    test_data_hold();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
